upower_cycle_sequencer: RTL and testbench
=========================================

# upower_cycle_sequencer

Multi-cycle sequencer for the uPOWER datapath. It steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK. It uses the decoded control flags (RegRead, RegWrite, MemRead, MemWrite, Branch) from the control unit to choose the path through those states. It sits between the control unit, the instruction/data memory ports and the PC/IR/register-file/ALU enables, and it owns instruction-level start, halt and illegal-instruction trapping.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters (only used with UPOWER_SEQ_PERF_EN)

Ports:
- clk  in  1  single clock for the block
- rst  in  1  synchronous, active-high reset
- start  in  1  leave IDLE and begin fetching
- halt_req  in  1  request a stop at the next instruction boundary
- reg_read, reg_write, mem_read, mem_write, branch  in  1 each  decoded control flags; valid in DECODE
- branch_taken  in  1  ALU branch condition; valid in EXECUTE
- imem_ready  in  1  instruction memory has returned data
- dmem_ready  in  1  data access has completed
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data access request
- dmem_we  out  1  write strobe qualifier for dmem_req
- ir_load  out  1  latch the instruction register
- rf_read_en, alu_en, rf_write_en  out  1 each  datapath enables
- pc_load  out  1  update the PC
- pc_sel  out  1  PC source: 0 = PC+4, 1 = branch target
- retire  out  1  one-cycle pulse when an instruction completes
- busy  out  1  state is not IDLE and not TRAP
- trap  out  1  illegal instruction; sticky until rst
- state  out  3  current state encoding
- instr_cnt, cycle_cnt  out  CNT_W each  present only with UPOWER_SEQ_PERF_EN

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, TRAP=6. Value 7 is unreachable and recovers to IDLE.
- IDLE: start -> FETCH. All enables are 0.
- FETCH: imem_req=1 for the whole state. When imem_ready=1, assert ir_load the same cycle and go to DECODE.
- DECODE: latch the five flags into internal registers; assert rf_read_en = reg_read.
  - If all five flags are 0, go to TRAP.
  - If mem_read and mem_write are both 1, go to TRAP.
  - Otherwise go to EXECUTE.
- EXECUTE: alu_en=1.
  - If latched branch: pc_load=1, pc_sel = branch_taken | ~reg_read (unconditional branches have reg_read=0), assert retire, then go to the boundary target.
  - Else if a memory flag is latched: go to MEMORY.
  - Else: go to WRITEBACK.
- MEMORY: dmem_req=1 and dmem_we = latched mem_write for the whole state. Wait for dmem_ready.
  - Load completes: go to WRITEBACK.
  - Store completes: pc_load=1, pc_sel=0, retire, then go to the boundary target.
- WRITEBACK: rf_write_en = latched reg_write, pc_load=1, pc_sel=0, retire, then go to the boundary target.
- Boundary target: IDLE if a halt is pending, else FETCH.
- halt_req handling:
  - halt_req sets a pending bit.
  - The pending bit is cleared when the sequencer enters IDLE.
  - start and halt_req asserted together in IDLE: exactly one instruction executes, then the sequencer returns to IDLE (single-step).
- TRAP: trap=1 and all enables are 0. Only rst leaves TRAP; start is ignored.

## Timing
- Reset: next edge gives state=IDLE with every output 0, the latched flags and halt-pending bit cleared, and the counters 0. Reset in any state, including while a request is outstanding, drops imem_req/dmem_req on the next cycle.
- Cycles per instruction with zero-wait memory (ready high in the first request cycle):
  - ALU instruction: 4
  - load: 5
  - store: 4
  - branch: 3
- Each memory wait cycle adds one cycle. A request is held stable until its ready is seen.
- ready asserted while no request is outstanding is ignored.
- Outputs decode from state and the latched flags. ir_load, retire and pc_load fire only on completing cycles.

## Configuration
- UPOWER_SEQ_PERF_EN defined:
  - cycle_cnt increments every cycle while busy.
  - instr_cnt increments on retire.
  - Both counters wrap modulo 2^CNT_W and clear on rst.
- Undefined: the counters and their ports are absent, and the behaviour is otherwise identical.

## Structure
- The shared package upower_pkg holds the state enum (3-bit), a ctrl_flags_t struct grouping the five flags, and the PC_SEL_SEQ/PC_SEL_BR constants.
- One sub-module, upower_perf_counters, instantiated only under UPOWER_SEQ_PERF_EN.

## Test plan
- add-type instruction (reg_read=reg_write=1), ready always high, start pulse -> states 1,2,3,5; rf_write_en and retire in cycle 4; back in FETCH.
- Load with dmem_ready delayed 3 cycles -> dmem_req high for 4 cycles with dmem_we=0; rf_write_en the cycle after ready; 8 cycles total.
- Conditional branch with branch_taken=1, then with 0 -> pc_sel=1 then 0, pc_load=1 in EXECUTE, 3 cycles each, no rf_write_en.
- Decode with all flags 0, and separately with mem_read=mem_write=1 -> TRAP, trap=1; start ignored; rst returns to IDLE.
- start and halt_req in the same cycle from IDLE -> one retire, then IDLE with busy=0.
- rst asserted in MEMORY with dmem_req high -> next cycle IDLE with all outputs 0; with UPOWER_SEQ_PERF_EN, counters read 0.

Source files
------------

// File: rtl/upower_cycle_sequencer_pkg.sv
// Shared types for the uPOWER multi-cycle sequencer: state encoding, decoded
// control-flag bundle and PC source select values.
package upower_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_TRAP      = 3'd6,
    ST_RSVD      = 3'd7
  } state_t;

  typedef struct packed {
    logic reg_read;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
  } ctrl_flags_t;

  localparam logic PC_SEL_SEQ = 1'b0;
  localparam logic PC_SEL_BR  = 1'b1;

  // No flags at all, or a simultaneous load and store, cannot be executed.
  function automatic logic flags_illegal(input ctrl_flags_t f);
    return (f == '0) || (f.mem_read && f.mem_write);
  endfunction

endpackage

// File: rtl/upower_cycle_sequencer_if.sv
// Handshake bundle between the sequencer, the control unit, the memory ports
// and the datapath enables.
interface upower_cycle_sequencer_if;

  logic       start;
  logic       halt_req;
  logic       reg_read;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       branch;
  logic       branch_taken;
  logic       imem_ready;
  logic       dmem_ready;
  logic       imem_req;
  logic       dmem_req;
  logic       dmem_we;
  logic       ir_load;
  logic       rf_read_en;
  logic       alu_en;
  logic       rf_write_en;
  logic       pc_load;
  logic       pc_sel;
  logic       retire;
  logic       busy;
  logic       trap;
  logic [2:0] state;

  modport master (
    output start, halt_req, reg_read, reg_write, mem_read, mem_write, branch,
           branch_taken, imem_ready, dmem_ready,
    input  imem_req, dmem_req, dmem_we, ir_load, rf_read_en, alu_en,
           rf_write_en, pc_load, pc_sel, retire, busy, trap, state
  );

  modport slave (
    input  start, halt_req, reg_read, reg_write, mem_read, mem_write, branch,
           branch_taken, imem_ready, dmem_ready,
    output imem_req, dmem_req, dmem_we, ir_load, rf_read_en, alu_en,
           rf_write_en, pc_load, pc_sel, retire, busy, trap, state
  );

endinterface

// File: rtl/upower_cycle_sequencer_perf.sv
// Free-running busy-cycle and retired-instruction counters for the sequencer.
module upower_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             busy,
  input  logic             retire,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_cnt <= '0;
      cycle_cnt <= '0;
    end else begin
      if (busy)   cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/upower_cycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with halt and
// illegal-instruction trap. Define UPOWER_SEQ_PERF_EN to add performance counters.
module upower_cycle_sequencer
  import upower_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  upower_cycle_sequencer_if.slave  bus
`ifdef UPOWER_SEQ_PERF_EN
  ,
  output logic [CNT_W-1:0]         instr_cnt,
  output logic [CNT_W-1:0]         cycle_cnt
`endif
);

  state_t      state_q, state_d;
  ctrl_flags_t flags_q, flags_in;
  logic        halt_pend_q;
  state_t      boundary;

  assign flags_in = '{reg_read:  bus.reg_read,  reg_write: bus.reg_write,
                      mem_read:  bus.mem_read,  mem_write: bus.mem_write,
                      branch:    bus.branch};
  assign boundary = halt_pend_q ? ST_IDLE : ST_FETCH;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      flags_q     <= '0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) flags_q <= flags_in;
      // A halt request is remembered until the sequencer actually reaches IDLE.
      if (state_d == ST_IDLE && state_q != ST_IDLE) halt_pend_q <= 1'b0;
      else if (bus.halt_req)                        halt_pend_q <= 1'b1;
    end
  end

  always_comb begin
    state_d         = state_q;
    bus.imem_req    = 1'b0;
    bus.dmem_req    = 1'b0;
    bus.dmem_we     = 1'b0;
    bus.ir_load     = 1'b0;
    bus.rf_read_en  = 1'b0;
    bus.alu_en      = 1'b0;
    bus.rf_write_en = 1'b0;
    bus.pc_load     = 1'b0;
    bus.pc_sel      = PC_SEL_SEQ;
    bus.retire      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ready) begin
          bus.ir_load = 1'b1;
          state_d     = ST_DECODE;
        end
      end
      ST_DECODE: begin
        bus.rf_read_en = bus.reg_read;
        state_d        = flags_illegal(flags_in) ? ST_TRAP : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        bus.alu_en = 1'b1;
        if (flags_q.branch) begin
          // Unconditional branches carry no register operand and always redirect.
          bus.pc_load = 1'b1;
          bus.pc_sel  = (bus.branch_taken || !flags_q.reg_read) ? PC_SEL_BR : PC_SEL_SEQ;
          bus.retire  = 1'b1;
          state_d     = boundary;
        end else if (flags_q.mem_read || flags_q.mem_write) begin
          state_d = ST_MEMORY;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_MEMORY: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = flags_q.mem_write;
        if (bus.dmem_ready) begin
          if (flags_q.mem_write) begin
            bus.pc_load = 1'b1;
            bus.retire  = 1'b1;
            state_d     = boundary;
          end else begin
            state_d = ST_WRITEBACK;
          end
        end
      end
      ST_WRITEBACK: begin
        bus.rf_write_en = flags_q.reg_write;
        bus.pc_load     = 1'b1;
        bus.retire      = 1'b1;
        state_d         = boundary;
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.state = state_q;
  assign bus.busy  = (state_q != ST_IDLE) && (state_q != ST_TRAP);
  assign bus.trap  = (state_q == ST_TRAP);

`ifdef UPOWER_SEQ_PERF_EN
  upower_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk       (clk),
    .rst       (rst),
    .busy      (bus.busy),
    .retire    (bus.retire),
    .instr_cnt (instr_cnt),
    .cycle_cnt (cycle_cnt)
  );
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_upower_cycle_sequencer.sv
// Directed + randomized bench for upower_cycle_sequencer against a per-instruction
// cycle model built from the instruction class and memory wait counts.
module tb_upower_cycle_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  longint exp_cyc = 0;
  longint exp_ins = 0;

  always #5 clk = ~clk;

  upower_cycle_sequencer_if bus();

`ifdef UPOWER_SEQ_PERF_EN
  logic [31:0] instr_cnt, cycle_cnt;
  upower_cycle_sequencer #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus), .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt));
`else
  upower_cycle_sequencer #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  // {state[2:0], imem_req, ir_load, rf_read_en, alu_en, dmem_req, dmem_we,
  //  rf_write_en, pc_load, pc_sel, retire, busy, trap}
  function automatic logic [14:0] obs();
    return {bus.state, bus.imem_req, bus.ir_load, bus.rf_read_en, bus.alu_en,
            bus.dmem_req, bus.dmem_we, bus.rf_write_en, bus.pc_load, bus.pc_sel,
            bus.retire, bus.busy, bus.trap};
  endfunction

  // o = {imem_req, ir_load, rf_read_en, alu_en, dmem_req, dmem_we, rf_write_en, pc_load, pc_sel, retire}
  function automatic logic [14:0] ex(input int st, input logic [9:0] o);
    logic [2:0] s;
    s = st[2:0];
    return {s, o, (st != 0 && st != 6), (st == 6)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic perf_chk(input string tag);
`ifdef UPOWER_SEQ_PERF_EN
    chk({tag, "_cycle_cnt"}, cycle_cnt, 32'(exp_cyc));
    chk({tag, "_instr_cnt"}, instr_cnt, 32'(exp_ins));
`else
    if (tag.len() == 0) chk("perf_tag", 32'(tag.len()), 32'd1);
`endif
  endtask

  // Randomize every input that should be irrelevant in the current cycle.
  task automatic noise();
    bus.start        = 1'b0;
    bus.halt_req     = 1'b0;
    bus.reg_read     = 1'($urandom);
    bus.reg_write    = 1'($urandom);
    bus.mem_read     = 1'($urandom);
    bus.mem_write    = 1'($urandom);
    bus.branch       = 1'($urandom);
    bus.branch_taken = 1'($urandom);
    bus.imem_ready   = 1'($urandom);
    bus.dmem_ready   = 1'($urandom);
  endtask

  task automatic cyc(input logic [14:0] e, input string tag);
    #1;
    chk(tag, 32'(obs()), 32'(e));
    if (e[1]) exp_cyc++;
    if (e[2]) exp_ins++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    noise();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cyc = 0;
    exp_ins = 0;
    noise();
    #1;
    chk("reset_outputs", 32'(obs()), 32'd0);
    perf_chk("reset");
    @(posedge clk);
    #1;
  endtask

  // f = {reg_read, reg_write, mem_read, mem_write, branch}
  task automatic run_instr(input logic [4:0] f, input int iw, input int dw,
                           input bit taken, input bit halt_first, input bit end_idle);
    bit rr, rw, mr, mw, br, illegal;
    {rr, rw, mr, mw, br} = f;
    illegal = (f == 5'd0) || (mr && mw);
    for (int i = 0; i <= iw; i++) begin
      noise();
      bus.imem_ready = (i == iw);
      bus.halt_req   = halt_first && (i == 0);
      cyc(ex(1, {1'b1, 1'(i == iw), 8'b0}), "fetch");
    end
    noise();
    {bus.reg_read, bus.reg_write, bus.mem_read, bus.mem_write, bus.branch} = f;
    cyc(ex(2, {2'b0, rr, 7'b0}), "decode");
    if (illegal) begin
      noise();
      cyc(ex(6, 10'b0), "trap_entry");
      return;
    end
    noise();
    bus.branch_taken = taken;
    cyc(ex(3, {3'b0, 1'b1, 3'b0, br, br && (taken || !rr), br}), "execute");
    if (!br) begin
      if (mr || mw) begin
        for (int j = 0; j <= dw; j++) begin
          bit done;
          done = mw && (j == dw);
          noise();
          bus.dmem_ready = (j == dw);
          cyc(ex(4, {4'b0, 1'b1, mw, 1'b0, done, 1'b0, done}), "memory");
        end
      end
      if (!mw) begin
        noise();
        cyc(ex(5, {6'b0, rw, 1'b1, 1'b0, 1'b1}), "writeback");
      end
    end
    if (end_idle) begin
      noise();
      cyc(ex(0, 10'b0), "halted_idle");
    end
  endtask

  function automatic logic [4:0] rand_legal();
    logic [4:0] f;
    do f = 5'($urandom_range(1, 31)); while (f[2] && f[1]);
    return f;
  endfunction

  initial begin
    noise();
    do_reset();

    // add-type instruction, zero-wait memory
    noise(); bus.start = 1'b1;
    cyc(ex(0, 10'b0), "idle_start");
    run_instr(5'b11000, 0, 0, 1'b0, 1'b0, 1'b0);
    // load with three data wait cycles
    run_instr(5'b11100, 0, 3, 1'b0, 1'b0, 1'b0);
    // conditional branch taken, then not taken
    run_instr(5'b10001, 0, 0, 1'b1, 1'b0, 1'b0);
    run_instr(5'b10001, 0, 0, 1'b0, 1'b0, 1'b0);
    // unconditional branch and a store
    run_instr(5'b00001, 1, 0, 1'b0, 1'b0, 1'b0);
    run_instr(5'b10010, 0, 2, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 30; n++)
      run_instr(rand_legal(), $urandom_range(0, 2), $urandom_range(0, 2),
                1'($urandom), 1'b0, 1'b0);
    run_instr(rand_legal(), $urandom_range(0, 2), $urandom_range(0, 2),
              1'($urandom), 1'b1, 1'b1);
    perf_chk("after_stream");

    // single-step: start and halt together
    noise(); bus.start = 1'b1; bus.halt_req = 1'b1;
    cyc(ex(0, 10'b0), "step_start");
    run_instr(rand_legal(), 0, 1, 1'($urandom), 1'b0, 1'b1);
    perf_chk("after_step");

    // illegal: no flags
    noise(); bus.start = 1'b1;
    cyc(ex(0, 10'b0), "idle_start2");
    run_instr(5'b00000, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      noise(); bus.start = 1'b1;
      cyc(ex(6, 10'b0), "trap_hold");
    end
    do_reset();

    // illegal: load and store together
    noise(); bus.start = 1'b1;
    cyc(ex(0, 10'b0), "idle_start3");
    run_instr(5'b11110, 1, 0, 1'b0, 1'b0, 1'b0);
    noise(); bus.start = 1'b1;
    cyc(ex(6, 10'b0), "trap_hold2");
    do_reset();

    // reset while a data request is outstanding
    noise(); bus.start = 1'b1;
    cyc(ex(0, 10'b0), "idle_start4");
    noise(); bus.imem_ready = 1'b1;
    cyc(ex(1, {2'b11, 8'b0}), "fetch_r");
    noise(); {bus.reg_read, bus.reg_write, bus.mem_read, bus.mem_write, bus.branch} = 5'b11100;
    cyc(ex(2, {3'b001, 7'b0}), "decode_r");
    noise();
    cyc(ex(3, {4'b0001, 6'b0}), "execute_r");
    noise(); bus.dmem_ready = 1'b0;
    cyc(ex(4, {5'b00001, 5'b0}), "memory_r");
    noise(); bus.dmem_ready = 1'b0;
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
